// File: rtl/boc_sig_tx.sv
// BOC(1,1) B1 ranging-signal transmitter: Gold code, half-chip code NCO, BOC subcarrier,
// NH/data-bit modulation and carrier NCO with cosine LUT, producing a signed 8-bit IF stream.
//
// state | meaning
// IDLE  | waiting for an accepted rx_start, outputs quiet
// SEEK  | advancing the LFSRs one chip per clock up to the start code phase
// RUN   | NCOs running, tx_sample valid
module boc_sig_tx #(
  parameter int ACC_WIDTH     = 32,
  parameter int PRN_PHS_WIDTH = 12,
  parameter int PRN_HALF_LEN  = 4092,
  parameter bit NH_EN         = 1'b1
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst_n,
  input  logic                     rx_start,
  input  logic                     rx_stop,
  input  logic [PRN_PHS_WIDTH-1:0] rx_init_phs,
  input  logic [3:0]               rx_g2_tap_a,
  input  logic [3:0]               rx_g2_tap_b,
  input  logic [ACC_WIDTH-1:0]     rx_prn_fcw,
  input  logic [ACC_WIDTH-1:0]     rx_car_fcw,
  input  logic                     rx_bit_vld,
  input  logic                     rx_bit,
  output logic                     tx_bit_rdy,
  output logic signed [7:0]        tx_sample,
  output logic                     tx_sample_vld,
  output logic                     tx_prn_sop,
  output logic [PRN_PHS_WIDTH-1:0] tx_prn_phs,
  output logic                     tx_busy,
  output logic                     tx_underrun
);

  localparam int SW = PRN_PHS_WIDTH - 1;
  localparam logic [10:0] LFSR_SEED = 11'b010_1010_1010;
  localparam logic [19:0] NH_SEQ    = 20'b0000_0100_1101_0100_1110;
  localparam logic [PRN_PHS_WIDTH-1:0] HALF_LEN = PRN_PHS_WIDTH'(PRN_HALF_LEN);
  localparam logic [PRN_PHS_WIDTH-1:0] PHS_LAST = PRN_PHS_WIDTH'(PRN_HALF_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEEK, RUN} state_t;
  state_t state, state_nxt;

  logic [11:1]          g1, g2;
  logic [15:0]          g2_ext;
  logic [3:0]           tap_a, tap_b;
  logic [SW-1:0]        seek_cnt;
  logic [ACC_WIDTH-1:0] prn_acc, car_acc;
  logic [ACC_WIDTH:0]   prn_sum;
  logic [4:0]           nh_idx;
  logic                 cur_bit, buf_full, buf_bit;
  logic                 carry, wrap, start_ok, seek_done, bit_bnd, bypass, buf_wr;
  logic                 chip, nh_bit, mod_bit;
  logic signed [7:0]    lut;

  function automatic logic [11:1] g1_step(input logic [11:1] g);
    return {g[10:1], g[1] ^ g[7] ^ g[8] ^ g[9] ^ g[10] ^ g[11]};
  endfunction

  function automatic logic [11:1] g2_step(input logic [11:1] g);
    return {g[10:1], g[1] ^ g[2] ^ g[3] ^ g[4] ^ g[5] ^ g[8] ^ g[9] ^ g[11]};
  endfunction

  assign prn_sum   = {1'b0, prn_acc} + {1'b0, rx_prn_fcw};
  assign carry     = prn_sum[ACC_WIDTH];
  assign wrap      = carry && (tx_prn_phs == PHS_LAST);
  assign start_ok  = rx_start && !rx_stop && (rx_init_phs < HALF_LEN);
  assign seek_done = (state == SEEK) && (seek_cnt <= SW'(1));
  assign bit_bnd   = !rx_stop && (seek_done || ((state == RUN) && wrap && (nh_idx == 5'd19)));
  // Bypass: the bit arrives exactly on an empty-buffer boundary and goes straight to cur_bit.
  assign bypass    = bit_bnd && !buf_full && rx_bit_vld;
  assign buf_wr    = rx_bit_vld && !buf_full && !bypass;

  assign g2_ext  = {4'b0000, g2, 1'b0};
  assign chip    = g1[11] ^ g2_ext[tap_a] ^ g2_ext[tap_b];
  assign nh_bit  = NH_EN & NH_SEQ[5'd19 - nh_idx];
  assign mod_bit = chip ^ tx_prn_phs[0] ^ nh_bit ^ cur_bit;

  assign tx_bit_rdy = !buf_full;
  assign tx_busy    = (state != IDLE);

  always_comb begin
    lut = 8'sd0;
    case (car_acc[ACC_WIDTH-1 -: 3])
      3'd0: lut = 8'sd127;
      3'd1: lut = 8'sd90;
      3'd2: lut = 8'sd0;
      3'd3: lut = -8'sd90;
      3'd4: lut = -8'sd127;
      3'd5: lut = -8'sd90;
      3'd6: lut = 8'sd0;
      3'd7: lut = 8'sd90;
      default: lut = 8'sd0;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = SEEK;
      SEEK: begin
        if (rx_stop)        state_nxt = IDLE;
        else if (seek_done) state_nxt = RUN;
      end
      RUN:  if (rx_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      g1            <= LFSR_SEED;
      g2            <= LFSR_SEED;
      tap_a         <= '0;
      tap_b         <= '0;
      seek_cnt      <= '0;
      prn_acc       <= '0;
      car_acc       <= '0;
      nh_idx        <= '0;
      cur_bit       <= 1'b0;
      buf_full      <= 1'b0;
      buf_bit       <= 1'b0;
      tx_prn_phs    <= '0;
      tx_prn_sop    <= 1'b0;
      tx_sample     <= '0;
      tx_sample_vld <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      tx_prn_sop    <= 1'b0;
      tx_sample     <= '0;
      tx_sample_vld <= 1'b0;

      if (bit_bnd && buf_full) begin
        buf_full <= 1'b0;
      end else if (buf_wr) begin
        buf_full <= 1'b1;
        buf_bit  <= rx_bit;
      end

      if (bit_bnd) begin
        if (buf_full)        cur_bit <= buf_bit;
        else if (rx_bit_vld) cur_bit <= rx_bit;
        else begin
          cur_bit     <= 1'b0;
          tx_underrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          // NCOs restart from zero so every run from a given phase is reproducible.
          if (start_ok) begin
            tap_a       <= rx_g2_tap_a;
            tap_b       <= rx_g2_tap_b;
            g1          <= LFSR_SEED;
            g2          <= LFSR_SEED;
            tx_prn_phs  <= rx_init_phs;
            seek_cnt    <= rx_init_phs[PRN_PHS_WIDTH-1:1];
            nh_idx      <= '0;
            prn_acc     <= '0;
            car_acc     <= '0;
            tx_underrun <= 1'b0;
          end
        end
        SEEK: begin
          if (!rx_stop && (seek_cnt != '0)) begin
            g1       <= g1_step(g1);
            g2       <= g2_step(g2);
            seek_cnt <= seek_cnt - SW'(1);
          end
        end
        RUN: begin
          if (!rx_stop) begin
            prn_acc       <= prn_sum[ACC_WIDTH-1:0];
            car_acc       <= car_acc + rx_car_fcw;
            tx_sample     <= mod_bit ? -lut : lut;
            tx_sample_vld <= 1'b1;
            if (wrap) begin
              tx_prn_phs <= '0;
              tx_prn_sop <= 1'b1;
              g1         <= LFSR_SEED;
              g2         <= LFSR_SEED;
              nh_idx     <= (nh_idx == 5'd19) ? 5'd0 : nh_idx + 5'd1;
            end else if (carry) begin
              tx_prn_phs <= tx_prn_phs + PRN_PHS_WIDTH'(1);
              if (tx_prn_phs[0]) begin
                g1 <= g1_step(g1);
                g2 <= g2_step(g2);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boc_sig_tx.sv
// Directed bench for boc_sig_tx: a golden PRN1 table plus a cycle model of the NCOs feeds
// a queue of expected samples that is drained as the DUT produces them.
module tb_boc_sig_tx;

  logic               rx_clk = 1'b0;
  logic               rx_rst_n;
  logic               rx_start, rx_stop, rx_bit_vld, rx_bit;
  logic [11:0]        rx_init_phs;
  logic [3:0]         rx_g2_tap_a, rx_g2_tap_b;
  logic [31:0]        rx_prn_fcw, rx_car_fcw;
  logic               tx_bit_rdy, tx_sample_vld, tx_prn_sop, tx_busy, tx_underrun;
  logic signed [7:0]  tx_sample;
  logic [11:0]        tx_prn_phs;

  boc_sig_tx #(.ACC_WIDTH(32), .PRN_PHS_WIDTH(12), .PRN_HALF_LEN(4092), .NH_EN(1'b1)) dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_start(rx_start), .rx_stop(rx_stop),
    .rx_init_phs(rx_init_phs), .rx_g2_tap_a(rx_g2_tap_a), .rx_g2_tap_b(rx_g2_tap_b),
    .rx_prn_fcw(rx_prn_fcw), .rx_car_fcw(rx_car_fcw), .rx_bit_vld(rx_bit_vld), .rx_bit(rx_bit),
    .tx_bit_rdy(tx_bit_rdy), .tx_sample(tx_sample), .tx_sample_vld(tx_sample_vld),
    .tx_prn_sop(tx_prn_sop), .tx_prn_phs(tx_prn_phs), .tx_busy(tx_busy), .tx_underrun(tx_underrun)
  );

  always #5 rx_clk = ~rx_clk;

  int errors = 0;
  int checks = 0;

  logic signed [7:0] exp_q[$];
  bit          chips[2046];
  logic [19:0] nh_seq = 20'b0000_0100_1101_0100_1110;
  int          lut[8] = '{127, 90, 0, -90, -127, -90, 0, 90};

  bit          m_run, m_sop, m_bit, m_unr, m_buf_full, m_buf_bit;
  logic [31:0] m_acc, m_car;
  int          m_phs, m_nh;

  task automatic chk(input string tag, input logic signed [31:0] obsv, input logic signed [31:0] expv);
    checks++;
    assert (obsv === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obsv, expv);
    end
  endtask

  // B1I Gold code: G1 = 1+x+x7+x8+x9+x10+x11, G2 = 1+x+x2+x3+x4+x5+x8+x9+x11, PRN1 taps 1 and 3.
  function automatic void gen_chips();
    bit s1[1:11];
    bit s2[1:11];
    bit f1, f2;
    for (int i = 1; i <= 11; i++) begin
      s1[i] = (i % 2 == 0);
      s2[i] = (i % 2 == 0);
    end
    for (int k = 0; k < 2046; k++) begin
      chips[k] = s1[11] ^ s2[1] ^ s2[3];
      f1 = s1[1] ^ s1[7] ^ s1[8] ^ s1[9] ^ s1[10] ^ s1[11];
      f2 = s2[1] ^ s2[2] ^ s2[3] ^ s2[4] ^ s2[5] ^ s2[8] ^ s2[9] ^ s2[11];
      for (int i = 11; i > 1; i--) begin
        s1[i] = s1[i-1];
        s2[i] = s2[i-1];
      end
      s1[1] = f1;
      s2[1] = f2;
    end
  endfunction

  function automatic logic signed [7:0] exp_sample();
    bit mb;
    int v;
    mb = chips[m_phs >> 1] ^ (m_phs % 2 == 1) ^ nh_seq[19 - m_nh] ^ m_bit;
    v  = lut[m_car[31:29]];
    return mb ? 8'(-v) : 8'(v);
  endfunction

  function automatic bit pred_carry();
    logic [32:0] s;
    s = {1'b0, m_acc} + {1'b0, rx_prn_fcw};
    return s[32];
  endfunction

  // One clock: queue the expected sample, advance the model, clock, compare.
  task automatic step();
    logic        c;
    bit          bnd;
    logic signed [7:0] e;
    bnd   = 0;
    m_sop = 0;
    if (m_run && !rx_stop) begin
      exp_q.push_back(exp_sample());
      {c, m_acc} = {1'b0, m_acc} + {1'b0, rx_prn_fcw};
      m_car = m_car + rx_car_fcw;
      if (c) begin
        if (m_phs == 4091) begin
          m_phs = 0;
          m_sop = 1;
          if (m_nh == 19) begin m_nh = 0; bnd = 1; end
          else m_nh++;
        end else m_phs++;
      end
    end
    if (bnd) begin
      if (m_buf_full) begin m_bit = m_buf_bit; m_buf_full = 0; end
      else if (rx_bit_vld) m_bit = rx_bit;
      else begin m_bit = 0; m_unr = 1; end
    end else if (rx_bit_vld && !m_buf_full) begin
      m_buf_full = 1;
      m_buf_bit  = rx_bit;
    end
    if (rx_stop) m_run = 0;
    @(posedge rx_clk); #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sample_vld", tx_sample_vld, 1);
      chk("sample", tx_sample, e);
    end else begin
      chk("vld_quiet", tx_sample_vld, 0);
    end
    chk("sop", tx_prn_sop, m_sop);
    if (m_run) chk("prn_phs", tx_prn_phs, m_phs);
    chk("underrun", tx_underrun, m_unr);
    chk("bit_rdy", tx_bit_rdy, !m_buf_full);
  endtask

  task automatic preload(input bit b);
    rx_bit_vld = 1'b1;
    rx_bit     = b;
    step();
    rx_bit_vld = 1'b0;
    rx_bit     = 1'b0;
  endtask

  task automatic start_run(input logic [11:0] init);
    int n;
    rx_init_phs = init;
    rx_start    = 1'b1;
    @(posedge rx_clk); #1;
    rx_start = 1'b0;
    m_unr    = 0;
    chk("accept_busy", tx_busy, 1);
    chk("accept_unr_clr", tx_underrun, 0);
    n = int'(init >> 1);
    if (n == 0) n = 1;
    for (int i = 0; i < n; i++) begin
      chk("seek_busy", tx_busy, 1);
      chk("seek_vld", tx_sample_vld, 0);
      @(posedge rx_clk); #1;
    end
    if (m_buf_full) begin m_bit = m_buf_bit; m_buf_full = 0; end
    else begin m_bit = 0; m_unr = 1; end
    chk("run_entry_phs", tx_prn_phs, init);
    chk("run_entry_vld", tx_sample_vld, 0);
    chk("run_entry_busy", tx_busy, 1);
    chk("run_entry_unr", tx_underrun, m_unr);
    chk("run_entry_rdy", tx_bit_rdy, !m_buf_full);
    m_run = 1;
    m_acc = '0;
    m_car = '0;
    m_nh  = 0;
    m_phs = int'(init);
  endtask

  task automatic stop_run();
    rx_stop = 1'b1;
    step();
    rx_stop = 1'b0;
    chk("stop_busy", tx_busy, 0);
    chk("stop_sample", tx_sample, 0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_sample"}, tx_sample, 0);
    chk({tag, "_vld"}, tx_sample_vld, 0);
    chk({tag, "_sop"}, tx_prn_sop, 0);
    chk({tag, "_phs"}, tx_prn_phs, 0);
    chk({tag, "_busy"}, tx_busy, 0);
    chk({tag, "_unr"}, tx_underrun, 0);
    chk({tag, "_rdy"}, tx_bit_rdy, 1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_run = 0; m_sop = 0; m_bit = 0; m_unr = 0; m_buf_full = 0; m_buf_bit = 0;
    m_acc = '0; m_car = '0; m_phs = 0; m_nh = 0;
  endtask

  initial begin
    int cnt;
    gen_chips();
    clear_model();
    rx_rst_n = 1'b0;  rx_start = 1'b0;  rx_stop = 1'b0;
    rx_bit_vld = 1'b0; rx_bit = 1'b0;   rx_init_phs = '0;
    rx_g2_tap_a = 4'd1; rx_g2_tap_b = 4'd3;
    rx_prn_fcw = 32'h8000_0000; rx_car_fcw = '0;
    #1;
    reset_vals("reset");
    @(posedge rx_clk); @(posedge rx_clk); #1;
    rx_rst_n = 1'b1;
    step();

    // PRN1, init 0: one full code period against the golden table, sop after 8184 cycles.
    preload(1'b0);
    start_run(12'd0);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (tx_prn_sop !== 1'b1 && cnt < 9000);
    chk("sop_period", cnt, 8184);

    // Fastest code rate to reach the 20th wrap, then supply the next bit on that exact cycle.
    rx_prn_fcw = 32'hFFFF_FFFF;
    cnt = 0;
    while (!(m_nh == 19 && m_phs == 4091 && pred_carry()) && cnt < 80000) begin
      step();
      cnt++;
    end
    chk("wrap20_phs", tx_prn_phs, 4091);
    rx_bit_vld = 1'b1;
    rx_bit     = 1'b1;
    step();
    rx_bit_vld = 1'b0;
    rx_bit     = 1'b0;
    chk("bypass_unr", tx_underrun, 0);
    for (int i = 0; i < 200; i++) step();
    stop_run();

    // Frozen code phase, carrier stepping one LUT entry per cycle.
    preload(1'b0);
    rx_prn_fcw = '0;
    rx_car_fcw = 32'h2000_0000;
    start_run(12'd0);
    for (int i = 0; i < 17; i++) step();
    stop_run();

    // Offset start without a preloaded bit: 50 seek cycles, underrun at RUN entry.
    rx_prn_fcw = 32'h8000_0000;
    rx_car_fcw = '0;
    start_run(12'd101);
    chk("offset_unr", tx_underrun, 1);
    for (int i = 0; i < 400; i++) step();
    stop_run();

    // Stop wins over start; out-of-range start phase is rejected.
    rx_start = 1'b1;
    rx_stop  = 1'b1;
    rx_init_phs = 12'd0;
    step();
    rx_start = 1'b0;
    rx_stop  = 1'b0;
    chk("start_stop_busy", tx_busy, 0);
    rx_init_phs = 12'd4092;
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    chk("reject_busy", tx_busy, 0);
    step();
    chk("reject_busy2", tx_busy, 0);
    chk("reject_unr_kept", tx_underrun, 1);

    // Async reset mid-RUN, then scenario 1 again from reset.
    preload(1'b0);
    start_run(12'd0);
    for (int i = 0; i < 100; i++) step();
    #2;
    rx_rst_n = 1'b0;
    #1;
    reset_vals("async_rst");
    clear_model();
    @(posedge rx_clk); #1;
    rx_rst_n = 1'b1;
    step();
    preload(1'b0);
    start_run(12'd0);
    for (int i = 0; i < 300; i++) step();
    stop_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
